// File: rtl/multi_tick_gen_pkg.sv
// Shared helpers for the multi-channel timebase: index widths, prescale ratio and limits.
package multi_tick_gen_pkg;

  localparam int unsigned MAX_CH = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero tick rate yields 0 so the caller's range check fires instead of a divide fault.
  function automatic int unsigned pre_ratio(input int unsigned clk_hz, input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/multi_tick_gen_tick_channel.sv
// One divider channel: counts base ticks, emits a 1-cycle tick and toggles a square output.
module tick_channel #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             base_tick,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             tick,
  output logic             sq
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    // A load takes precedence over a coinciding terminal event, suppressing its tick.
    if (load) begin
      div_d = load_div;
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en && base_tick && (div_q != '0)) begin
      if (cnt_q == div_q - ONE) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DEF_DIV_V;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/multi_tick_gen.sv
// Timebase top: shared prescaler producing base_tick, plus NUM_CH loadable divider channels.
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1_000_000,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEF_DIV     = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          load,
  input  logic [idx_width(NUM_CH)-1:0]  load_ch,
  input  logic [DIV_W-1:0]              load_div,
  output logic                          base_tick,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             sq
);

  localparam int unsigned PRE   = pre_ratio(CLK_FREQ_HZ, TICK_HZ);
  localparam int unsigned PRE_W = idx_width(PRE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);

  if (PRE < 2) begin : g_bad_pre
    $error("multi_tick_gen: CLK_FREQ_HZ/TICK_HZ must be at least 2");
  end
  if ((NUM_CH < 1) || (NUM_CH > MAX_CH)) begin : g_bad_num_ch
    $error("multi_tick_gen: NUM_CH must be within 1..16");
  end

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              base_tick_q, base_tick_d;
  logic [NUM_CH-1:0] ch_load;

  always_comb begin
    pre_cnt_d   = pre_cnt_q + PRE_W'(1);
    base_tick_d = 1'b0;
    if (pre_cnt_q == PRE_LAST) begin
      pre_cnt_d   = '0;
      base_tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  // Channel indices with no matching instance simply decode to nothing.
  always_comb begin
    ch_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_load[i] = load && (int'(load_ch) == i);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tick_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[gi]),
      .base_tick (base_tick_q),
      .load      (ch_load[gi]),
      .load_div  (load_div),
      .tick      (tick[gi]),
      .sq        (sq[gi])
    );
  end

  assign base_tick = base_tick_q;

endmodule
